// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and counter-width helper for piso_reader.
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} piso_state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/piso_reader_bit_counter.sv
// bit_counter: frame bit index, saturating at N-1 so it never wraps within a frame.
module bit_counter
  import piso_pkg::*;
#(
  parameter int N = 8,
  localparam int W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         rst_cnt,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == W'(N - 1);
  assign cnt = cnt_q;
  always_comb cnt_d = rst_cnt ? '0 : (inc && !last) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge clear)
    if (clear) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/piso_reader.sv
// piso_reader: captures a parallel word and streams it out serially with valid/done framing.
// Optional even-parity trailer bit is enabled by defining PISO_READER_PARITY_EN.
module piso_reader
  import piso_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] in,
  input  logic         shift_en,
  output logic         ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         done
);
  localparam int W = cnt_w(N);
`ifdef PISO_READER_PARITY_EN
  localparam piso_state_t AFTER_LAST = PARITY;
`else
  localparam piso_state_t AFTER_LAST = DONE;
`endif
  piso_state_t state_q, state_d;
  logic [N-1:0] sr_q, sr_d;
  logic [W-1:0] cnt, idx;
  logic last, par_bit;
  bit_counter #(.N(N)) u_cnt (
    .clk(clk),
    .clear(clear),
    .rst_cnt(state_q == IDLE),
    .inc(state_q == SHIFT && shift_en),
    .cnt(cnt),
    .last(last)
  );
  // The captured word is held still; the counter selects which bit is presented.
  assign idx = MSB_FIRST ? W'(N - 1) - cnt : cnt;
`ifdef PISO_READER_PARITY_EN
  assign par_bit = (state_q == PARITY) && (^sr_q);
`else
  assign par_bit = 1'b0;
`endif
  assign ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign ser_valid = state_q == SHIFT || state_q == PARITY;
  assign ser_out = (state_q == SHIFT) ? sr_q[idx] : par_bit;
  always_comb begin
    state_d = (state_q == IDLE)   ? (load ? SHIFT : IDLE) :
              (state_q == SHIFT)  ? ((shift_en && last) ? AFTER_LAST : SHIFT) :
              (state_q == PARITY) ? (shift_en ? DONE : PARITY) : IDLE;
    sr_d = (state_q == IDLE && load) ? in : sr_q;
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state_q <= IDLE;
      sr_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
    end
endmodule
